cu_program_sequencer: RTL and testbench

Program sequencer and instruction decoder for the 4-bit computational unit. It fetches 8-bit instructions from a combinational program memory and registers them in `ir`. Each instruction is decoded into the unit's `source_sel`, `reg_en`, `i_sel`, `x_sel`, `y_sel` and `ir_nibble` controls. Conditional jumps use the unit's registered `r_eq_0` flag.

---
 rtl/cu_ctrl_pkg.sv | 67 ++++++
 rtl/cu_insn_decode.sv | 48 ++++
 rtl/cu_program_sequencer.sv | 116 +++++++++++
 tb/tb_cu_program_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_ctrl_pkg.sv
// Shared constants and types for the computational-unit program sequencer.
// Optional feature macro: CU_SEQ_HALT_EN (adds the HALT opcode and HALTED state).
package cu_ctrl_pkg;

  // Opcode prefixes
  localparam logic       OP_LOAD_PFX = 1'b0;
  localparam logic [1:0] OP_MOV_PFX  = 2'b10;
  localparam logic [2:0] OP_ALU_PFX  = 3'b110;
  localparam logic [2:0] OP_JUMP_PFX = 3'b111;

  // Jump condition codes
  localparam logic [1:0] CC_JMP = 2'b00;
  localparam logic [1:0] CC_JZ  = 2'b01;
  localparam logic [1:0] CC_JNZ = 2'b10;
  localparam logic [1:0] CC_NOP = 2'b11;

  localparam logic [7:0] NOP_BYTE  = 8'hF8;
  localparam logic [7:0] HALT_BYTE = 8'hFF;

  // Destination codes
  localparam logic [2:0] DST_X0 = 3'd0;
  localparam logic [2:0] DST_X1 = 3'd1;
  localparam logic [2:0] DST_Y0 = 3'd2;
  localparam logic [2:0] DST_Y1 = 3'd3;
  localparam logic [2:0] DST_O  = 3'd4;
  localparam logic [2:0] DST_M  = 3'd5;
  localparam logic [2:0] DST_I  = 3'd6;
  localparam logic [2:0] DST_DM = 3'd7;

  // Source code that triggers i auto-increment on MOV
  localparam logic [2:0] SRC_DM = 3'd7;

  // Extra data-bus sources beyond the register codes
  localparam logic [3:0] SRC_SEL_PM    = 4'd8;
  localparam logic [3:0] SRC_SEL_IPINS = 4'd9;

  // reg_en bit for r (ALU result) and i
  localparam int EN_R = 4;
  localparam int EN_I = 6;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_FLUSH
`ifdef CU_SEQ_HALT_EN
    , ST_HALTED
`endif
  } seq_state_t;

  // Map a destination code onto its one-hot register enable.
  function automatic logic [8:0] dst_enable(input logic [2:0] dst);
    logic [8:0] en;
    en = '0;
    case (dst)
      DST_X0:  en[0] = 1'b1;
      DST_X1:  en[1] = 1'b1;
      DST_Y0:  en[2] = 1'b1;
      DST_Y1:  en[3] = 1'b1;
      DST_O:   en[8] = 1'b1;
      DST_M:   en[5] = 1'b1;
      DST_I:   en[6] = 1'b1;
      default: en[7] = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/cu_insn_decode.sv
// Purely combinational decode of the instruction register into unit controls.
// Jump opcodes (including NOP and, when enabled, HALT) decode to all-zero controls.
module cu_insn_decode
  import cu_ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic [3:0] ir_nibble,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel
);

  logic auto_inc;

  // Field decode per instruction class, then overlay i auto-increment.
  always_comb begin
    reg_en     = '0;
    source_sel = '0;
    ir_nibble  = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    auto_inc   = 1'b0;
    if (ir[7] == OP_LOAD_PFX) begin
      reg_en     = dst_enable(ir[6:4]);
      source_sel = SRC_SEL_PM;
      ir_nibble  = ir[3:0];
      auto_inc   = (ir[6:4] == DST_DM);
    end else if (ir[7:6] == OP_MOV_PFX) begin
      reg_en     = dst_enable(ir[5:3]);
      // A self-move is meaningless, so that encoding reads the input pins.
      source_sel = (ir[2:0] == ir[5:3]) ? SRC_SEL_IPINS : {1'b0, ir[2:0]};
      auto_inc   = ((ir[5:3] == DST_DM) || (ir[2:0] == SRC_DM)) && (ir[5:3] != DST_I);
    end else if (ir[7:5] == OP_ALU_PFX) begin
      reg_en[EN_R] = 1'b1;
      x_sel        = ir[4];
      y_sel        = ir[3];
      ir_nibble    = {1'b0, ir[2:0]};
    end
    if (auto_inc) begin
      reg_en[EN_I] = 1'b1;
      i_sel        = 1'b1;
    end
  end

endmodule

// File: rtl/cu_program_sequencer.sv
// Program sequencer: program counter, instruction register and fetch FSM.
// Optional feature macro: CU_SEQ_HALT_EN (8'hFF halts until sync_reset).
module cu_program_sequencer
  import cu_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            sync_reset,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  output logic [PC_W-1:0] pm_address,
  output logic [7:0]      ir,
  output logic [3:0]      ir_nibble,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel
);

  seq_state_t      state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [7:0]      ir_nxt;
  logic            is_jump, taken, quiet;
  logic [8:0]      dec_reg_en;
  logic [3:0]      dec_source_sel, dec_ir_nibble;
  logic            dec_i_sel, dec_x_sel, dec_y_sel;

  cu_insn_decode u_decode (
    .ir         (ir),
    .reg_en     (dec_reg_en),
    .source_sel (dec_source_sel),
    .ir_nibble  (dec_ir_nibble),
    .i_sel      (dec_i_sel),
    .x_sel      (dec_x_sel),
    .y_sel      (dec_y_sel)
  );

  // State, pc and ir registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state      <= ST_RESET;
      pm_address <= '0;
      ir         <= NOP_BYTE;
    end else begin
      state      <= state_nxt;
      pm_address <= pc_nxt;
      ir         <= ir_nxt;
    end
  end

  // Next-state, pc and ir selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pm_address;
    ir_nxt    = ir;
    is_jump   = (ir[7:5] == OP_JUMP_PFX) && (ir[4:3] != CC_NOP);
    taken     = (ir[4:3] == CC_JMP) ||
                ((ir[4:3] == CC_JZ)  &&  r_eq_0) ||
                ((ir[4:3] == CC_JNZ) && !r_eq_0);
    case (state)
      ST_RUN: begin
        if (is_jump) begin
          // pc already points at the target byte here.
          pc_nxt    = taken ? PC_W'(pm_data) : pm_address + PC_W'(1);
          ir_nxt    = NOP_BYTE;
          state_nxt = ST_FLUSH;
`ifdef CU_SEQ_HALT_EN
        end else if (ir == HALT_BYTE) begin
          state_nxt = ST_HALTED;
`endif
        end else begin
          pc_nxt = pm_address + PC_W'(1);
          ir_nxt = pm_data;
        end
      end
`ifdef CU_SEQ_HALT_EN
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
`endif
      default: begin
        // RESET and FLUSH both hold a NOP and perform a plain fetch.
        pc_nxt    = pm_address + PC_W'(1);
        ir_nxt    = pm_data;
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Output override: reset clears r through reg_en[4]; halt silences everything.
  always_comb begin
`ifdef CU_SEQ_HALT_EN
    quiet = (state == ST_HALTED) || (ir == HALT_BYTE);
`else
    quiet = 1'b0;
`endif
    reg_en     = dec_reg_en;
    source_sel = dec_source_sel;
    ir_nibble  = dec_ir_nibble;
    i_sel      = dec_i_sel;
    x_sel      = dec_x_sel;
    y_sel      = dec_y_sel;
    if (sync_reset || quiet) begin
      reg_en     = '0;
      source_sel = '0;
      ir_nibble  = '0;
      i_sel      = 1'b0;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      reg_en[EN_R] = sync_reset;
    end
  end

endmodule

// File: tb/tb_cu_program_sequencer.sv
// Self-checking bench for cu_program_sequencer: directed literal checks plus a
// randomized run compared every cycle against an architectural model.
module tb_cu_program_sequencer;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            sync_reset;
  logic            r_eq_0;
  logic [7:0]      pm_data;
  logic [PC_W-1:0] pm_address;
  logic [7:0]      ir;
  logic [3:0]      ir_nibble, source_sel;
  logic [8:0]      reg_en;
  logic            i_sel, x_sel, y_sel;

  logic [7:0] pm [256];
  assign pm_data = pm[pm_address];

  cu_program_sequencer #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
    .pm_address (pm_address),
    .ir         (ir),
    .ir_nibble  (ir_nibble),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

`ifdef CU_SEQ_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: an instruction either executes and the next byte is
  // fetched, or it is a conditional/unconditional jump that consumes the
  // following byte and leaves a NOP bubble, or it is HALT which repeats forever.
  logic [7:0] m_pc, m_ir;

  function automatic bit is_branch(input logic [7:0] b);
    return (b[7:5] == 3'b111) && (b[4:3] != 2'b11);
  endfunction

  always @(posedge clk) begin
    if (sync_reset) begin
      m_pc <= 8'h00;
      m_ir <= 8'hF8;
    end else if (is_branch(m_ir)) begin
      if (m_ir[4:3] == 2'b00 || (m_ir[4:3] == 2'b01 && r_eq_0) || (m_ir[4:3] == 2'b10 && !r_eq_0))
        m_pc <= pm[m_pc];
      else
        m_pc <= m_pc + 8'd1;
      m_ir <= 8'hF8;
    end else if (HALT_ON && m_ir == 8'hFF) begin
      m_pc <= m_pc;
    end else begin
      m_ir <= pm[m_pc];
      m_pc <= m_pc + 8'd1;
    end
  end

  // Expected controls for an instruction byte, straight from the format rules.
  function automatic void expect_ctl(input logic [7:0] b, output logic [8:0] en,
                                     output logic [3:0] src, output logic [3:0] nib,
                                     output logic is, output logic xs, output logic ys);
    int dst_bit [8] = '{0, 1, 2, 3, 8, 5, 6, 7};
    int d, s;
    bit inc;
    en = '0; src = '0; nib = '0; is = 0; xs = 0; ys = 0; inc = 0;
    if (b < 8'h80) begin
      d = int'(b[6:4]);
      en[dst_bit[d]] = 1'b1;
      src = 4'd8;
      nib = b[3:0];
      inc = (d == 7);
    end else if (b < 8'hC0) begin
      d = int'(b[5:3]);
      s = int'(b[2:0]);
      en[dst_bit[d]] = 1'b1;
      src = (s == d) ? 4'd9 : 4'(s);
      inc = (d == 7 || s == 7) && d != 6;
    end else if (b < 8'hE0) begin
      en[4] = 1'b1;
      xs = b[4];
      ys = b[3];
      nib = {1'b0, b[2:0]};
    end
    if (inc) begin
      en[6] = 1'b1;
      is = 1'b1;
    end
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [8:0] e_en;
    logic [3:0] e_src, e_nib;
    logic e_is, e_xs, e_ys;
    if (chk_en) begin
      if (sync_reset) begin
        e_en = 9'h010; e_src = '0; e_nib = '0; e_is = 0; e_xs = 0; e_ys = 0;
      end else begin
        expect_ctl(m_ir, e_en, e_src, e_nib, e_is, e_xs, e_ys);
      end
      check("m_pc", 32'(pm_address), 32'(m_pc));
      check("m_ir", 32'(ir), 32'(m_ir));
      check("m_reg_en", 32'(reg_en), 32'(e_en));
      check("m_source_sel", 32'(source_sel), 32'(e_src));
      check("m_ir_nibble", 32'(ir_nibble), 32'(e_nib));
      check("m_sels", {29'd0, i_sel, x_sel, y_sel}, {29'd0, e_is, e_xs, e_ys});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_directed();
    for (int a = 0; a < 256; a++) pm[a] = 8'hF8;
    pm[0] = 8'h0A; pm[1] = 8'hBF; pm[2] = 8'hB7; pm[3] = 8'hD1;
    pm[4] = 8'hE8; pm[5] = 8'h20; pm[6] = 8'h3C; pm[8'h20] = 8'h15;
  endtask

  initial begin
    sync_reset = 1'b1;
    r_eq_0 = 1'b0;
    load_directed();
    step(); step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pc", 32'(pm_address), 32'h0);
    check("rst_ir", 32'(ir), 32'hF8);
    check("rst_reg_en", 32'(reg_en), 32'h010);

    // Taken JZ
    step(); sync_reset = 1'b0; r_eq_0 = 1'b1;
    step(); @(negedge clk);
    check("load_reg_en", 32'(reg_en), 32'h001);
    check("load_src", 32'(source_sel), 32'h8);
    check("load_nib", 32'(ir_nibble), 32'hA);
    step(); @(negedge clk);
    check("movBF_src", 32'(source_sel), 32'h9);
    check("movBF_en", 32'(reg_en), 32'h0C0);
    check("movBF_isel", 32'(i_sel), 32'h1);
    step(); @(negedge clk);
    check("movB7_en", 32'(reg_en), 32'h040);
    check("movB7_isel", 32'(i_sel), 32'h0);
    step(); @(negedge clk);
    check("alu_en", 32'(reg_en), 32'h010);
    check("alu_sel", {30'd0, x_sel, y_sel}, 32'h2);
    check("alu_nib", 32'(ir_nibble), 32'h1);
    step(); @(negedge clk);
    check("jz_ir", 32'(ir), 32'hE8);
    check("jz_en", 32'(reg_en), 32'h000);
    step(); @(negedge clk);
    check("jz_taken_pc", 32'(pm_address), 32'h20);
    check("jz_flush_ir", 32'(ir), 32'hF8);
    step(); @(negedge clk);
    check("jz_target_ir", 32'(ir), 32'h15);
    check("jz_target_pc", 32'(pm_address), 32'h21);

    // Not-taken JZ, then reset during FLUSH
    sync_reset = 1'b1;
    step(); sync_reset = 1'b0; r_eq_0 = 1'b0;
    for (int k = 0; k < 5; k++) step();
    step(); @(negedge clk);
    check("jz_nt_pc", 32'(pm_address), 32'h06);
    check("jz_nt_ir", 32'(ir), 32'hF8);
    step(); @(negedge clk);
    check("jz_nt_next_ir", 32'(ir), 32'h3C);
    sync_reset = 1'b1;
    for (int k = 0; k < 4; k++) step();
    sync_reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    step(); sync_reset = 1'b1;
    @(negedge clk);
    check("flush_rst_en", 32'(reg_en), 32'h010);
    step(); @(negedge clk);
    check("flush_rst_pc", 32'(pm_address), 32'h0);
    check("flush_rst_ir", 32'(ir), 32'hF8);

    // Jump at the last address takes its target from address 0
    pm[0] = 8'hE0; pm[1] = 8'hFF; pm[8'hFF] = 8'hE0;
    step(); sync_reset = 1'b0;
    step(); step(); @(negedge clk);
    check("wrap_jmp_pc", 32'(pm_address), 32'hFF);
    step(); step(); @(negedge clk);
    check("wrap_target_pc", 32'(pm_address), 32'hE0);

`ifdef CU_SEQ_HALT_EN
    sync_reset = 1'b1;
    pm[0] = 8'h0A; pm[1] = 8'hFF;
    step(); sync_reset = 1'b0;
    step(); step(); step();
    for (int k = 0; k < 10; k++) begin
      step(); @(negedge clk);
      check("halt_pc", 32'(pm_address), 32'h2);
      check("halt_en", 32'(reg_en), 32'h0);
    end
    sync_reset = 1'b1;
    step(); sync_reset = 1'b0;
    step(); @(negedge clk);
    check("halt_recover_ir", 32'(ir), 32'h0A);
`endif

    // Randomized programs, flag and occasional reset
    sync_reset = 1'b1;
    for (int a = 0; a < 256; a++) begin
      pm[a] = 8'($urandom_range(0, 254));
    end
    step(); sync_reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step();
      r_eq_0 = 1'($urandom_range(0, 1));
      sync_reset = ($urandom_range(0, 99) == 0);
    end
    step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
